// File: rtl/fifo_rd_sched.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_sched
// Purpose  : Read-side controller of a dual-clock gray-pointer FIFO, entirely
//            in the rclk domain. Owns the binary/gray read pointer, derives
//            rempty from the synchronized write pointer, and shares the single
//            read port among NUM_REQ consumers using round-robin grants that
//            rotate after at most MAX_BURST pops.
// Ports    : rclk, rrst_n     clock, async active-low reset
//            rq2_wptr         gray write pointer already synchronized to rclk
//            req, ready       per-consumer request / accept-current-word
//            gnt              registered one-hot grant
//            rvalid           gnt qualified by ~rempty (combinational)
//            raddr            binary read address to the FIFO memory
//            rptr             registered gray read pointer to the write side
//            rempty           registered empty flag
//            rlevel           occupied words (0 unless level option built in)
// Options  : FIFO_RD_SCHED_LEVEL_EN - when defined, rlevel is a registered
//            occupancy count; otherwise rlevel is tied to 0.
// Revision : 1.0  initial release
// ============================================================================
module fifo_rd_sched #(
  parameter int ADDRSIZE  = 4,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [NUM_REQ-1:0]  req,
  input  logic [NUM_REQ-1:0]  ready,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [NUM_REQ-1:0]  rvalid,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic [ADDRSIZE:0]   rlevel
);

  localparam int         IDXW      = $clog2(NUM_REQ);
  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  // --------------------------------------------------------------------------
  // Read pointer and empty flag
  // --------------------------------------------------------------------------
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] rbin_next;
  logic [ADDRSIZE:0] rgray_next;
  logic              pop;

  // Only the granted consumer can accept; ready of others is masked by gnt.
  assign pop        = (|(gnt & ready)) & ~rempty;
  assign rbin_next  = rbin + {{ADDRSIZE{1'b0}}, pop};
  assign rgray_next = rbin_next ^ (rbin_next >> 1);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin   <= '0;
      rptr   <= '0;
      rempty <= 1'b1;
    end else begin
      rbin   <= rbin_next;
      rptr   <= rgray_next;
      // Compare against the post-pop pointer so empty is flagged the cycle
      // after the last word leaves, not one cycle late.
      rempty <= (rgray_next == rq2_wptr);
    end
  end

  assign raddr  = rbin[ADDRSIZE-1:0];
  assign rvalid = gnt & {NUM_REQ{~rempty}};

  // --------------------------------------------------------------------------
  // Round-robin pick: first requester at or above rr_ptr, circularly
  // --------------------------------------------------------------------------
  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] pick_idx;
  logic            pick_found;
  int              cand;

  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    cand       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!pick_found && req[IDXW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDXW'(cand);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Grant FSM
  // --------------------------------------------------------------------------
  logic [0:0]         state;
  logic [0:0]         state_next;
  logic [NUM_REQ-1:0] gnt_next;
  logic [7:0]         beat;
  logic [7:0]         beat_next;
  logic [IDXW-1:0]    gidx;
  logic [IDXW-1:0]    gidx_next;
  logic [IDXW-1:0]    rr_next;
  logic               release_gnt;

  // An empty FIFO never releases the grant by itself; only a completed burst
  // or the holder dropping its request does. A pop coinciding with a request
  // drop still completes because pop does not depend on req.
  assign release_gnt = (pop && (beat == LAST_BEAT)) || !req[gidx];

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state  <= S_IDLE;
      gnt    <= '0;
      beat   <= '0;
      gidx   <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_next;
      gnt    <= gnt_next;
      beat   <= beat_next;
      gidx   <= gidx_next;
      rr_ptr <= rr_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (|req)       state_next = S_GRANT;
      S_GRANT: if (release_gnt) state_next = S_IDLE;
      default:                 state_next = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_next  = gnt;
    beat_next = beat;
    gidx_next = gidx;
    rr_next   = rr_ptr;
    case (state)
      S_IDLE: begin
        // Granting is independent of rempty; the holder simply waits.
        if (|req) begin
          gnt_next  = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
          beat_next = '0;
          gidx_next = pick_idx;
        end
      end
      S_GRANT: begin
        if (release_gnt) begin
          // Going through IDLE gives exactly one bubble between grants.
          gnt_next = '0;
          rr_next  = (gidx == IDXW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
        end else begin
          beat_next = beat + 8'(pop);
        end
      end
      default: begin
        gnt_next = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Optional occupancy count
  // --------------------------------------------------------------------------
`ifdef FIFO_RD_SCHED_LEVEL_EN
  logic [ADDRSIZE:0] wbin;

  // Gray-to-binary: each binary bit is the XOR of all gray bits at or above it.
  for (genvar i = 0; i <= ADDRSIZE; i++) begin : g_g2b
    assign wbin[i] = ^rq2_wptr[ADDRSIZE:i];
  end

  // Using the post-pop pointer and a synchronized (older) write pointer keeps
  // the count from ever over-reporting.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rlevel <= '0;
    end else begin
      rlevel <= wbin - rbin_next;
    end
  end
`else
  assign rlevel = '0;
`endif

endmodule
`default_nettype wire
